// File: rtl/cache_nway_wb.sv
// cache_nway_wb: N-way set-associative write-back/write-allocate cache with tree PLRU and memory handshake.
// Defining CACHE_STATS_EN adds saturating hit/miss counters oHitCnt/oMissCnt.
module cache_nway_wb #(
   parameter int WAYS = 4,
   parameter int SET_BITS = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic iRd,
   input  logic iWr,
   input  logic [ADDR_W-1:0] iAddr,
   input  logic [DATA_W-1:0] iData,
   output logic oBusy,
   output logic oReady,
   output logic oHit,
   output logic [DATA_W-1:0] oData,
   output logic oMemRd,
   output logic oMemWr,
   output logic [ADDR_W-1:0] oMemAddr,
   output logic [DATA_W-1:0] oMemData,
   input  logic [DATA_W-1:0] iMemData,
   input  logic iMemAck
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0] oHitCnt,
   output logic [31:0] oMissCnt
`endif
);
   localparam int SETS = 1 << SET_BITS;
   localparam int LOG = $clog2(WAYS);
   localparam int TAG_W = ADDR_W - SET_BITS - 2;
   typedef enum logic [2:0] {INIT, IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} stateT;
   stateT state, nextState;
   logic [WAYS-1:0] valid [SETS];
   logic [WAYS-1:0] dirty [SETS];
   // Heap-ordered tree: root at bit 1, children of n at 2n/2n+1, bit 0 unused.
   logic [WAYS-1:0] plru [SETS];
   logic [TAG_W-1:0] tags [SETS][WAYS];
   logic [DATA_W-1:0] lines [SETS][WAYS];
   logic reqWr, hit;
   logic [TAG_W-1:0] reqTag;
   logic [SET_BITS-1:0] reqIdx, initIdx;
   logic [DATA_W-1:0] reqData, memData, dataHold;
   logic [LOG-1:0] vicWay, hitWay, plruWay, missWay, accWay;
   logic [WAYS-1:0] treeCur, treeNew;
   logic [LOG:0] node, upd;
   logic unusedAddr;
   assign unusedAddr = ^iAddr[1:0];
   always_comb begin
      treeCur = plru[reqIdx];
      node = (LOG+1)'(1);
      for (int l = 0; l < LOG; l++) node = {node[LOG-1:0], treeCur[node[LOG-1:0]]};
      plruWay = node[LOG-1:0];
   end
   always_comb begin
      hit = 1'b0;
      hitWay = '0;
      missWay = plruWay;
      for (int w = WAYS-1; w >= 0; w--) begin
         if (valid[reqIdx][w] && tags[reqIdx][w] == reqTag) begin
            hit = 1'b1;
            hitWay = LOG'(w);
         end
         if (!valid[reqIdx][w]) missWay = LOG'(w);
      end
   end
   always_comb begin
      accWay = (state == LOOKUP) ? hitWay : vicWay;
      treeNew = treeCur;
      upd = (LOG+1)'(1);
      for (int l = LOG-1; l >= 0; l--) begin
         treeNew[upd[LOG-1:0]] = ~accWay[l];
         upd = {upd[LOG-1:0], accWay[l]};
      end
   end
   always_comb begin
      nextState = state;
      oBusy = 1'b1;
      oReady = 1'b0;
      oHit = 1'b0;
      oData = dataHold;
      oMemRd = 1'b0;
      oMemWr = 1'b0;
      oMemAddr = '0;
      oMemData = '0;
      case (state)
         INIT: nextState = (initIdx == '1) ? IDLE : INIT;
         IDLE: begin
            oBusy = 1'b0;
            nextState = (iRd | iWr) ? LOOKUP : IDLE;
         end
         LOOKUP: begin
            oReady = hit;
            oHit = hit;
            oData = !hit ? dataHold : reqWr ? reqData : lines[reqIdx][hitWay];
            nextState = hit ? IDLE : (valid[reqIdx][missWay] && dirty[reqIdx][missWay]) ? WRITEBACK : reqWr ? RESPOND : REFILL;
         end
         WRITEBACK: begin
            oMemWr = 1'b1;
            oMemAddr = {tags[reqIdx][vicWay], reqIdx, 2'b00};
            oMemData = lines[reqIdx][vicWay];
            nextState = !iMemAck ? WRITEBACK : reqWr ? RESPOND : REFILL;
         end
         REFILL: begin
            oMemRd = 1'b1;
            oMemAddr = {reqTag, reqIdx, 2'b00};
            nextState = iMemAck ? RESPOND : REFILL;
         end
         RESPOND: begin
            oReady = 1'b1;
            oData = reqWr ? reqData : memData;
            nextState = IDLE;
         end
         default: nextState = INIT;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= INIT;
         initIdx <= '0;
         dataHold <= '0;
      end else begin
         state <= nextState;
         if (oReady) dataHold <= oData;
         if (state == INIT) begin
            initIdx <= initIdx + 1'b1;
            valid[initIdx] <= '0;
            dirty[initIdx] <= '0;
            plru[initIdx] <= '0;
         end
         if (state == IDLE) begin
            reqWr <= iWr;
            reqTag <= iAddr[ADDR_W-1:SET_BITS+2];
            reqIdx <= iAddr[SET_BITS+1:2];
            reqData <= iData;
         end
         if (state == LOOKUP) begin
            vicWay <= missWay;
            if (hit) plru[reqIdx] <= treeNew;
            if (hit && reqWr) begin
               lines[reqIdx][hitWay] <= reqData;
               dirty[reqIdx][hitWay] <= 1'b1;
            end
         end
         if (state == REFILL && iMemAck) memData <= iMemData;
         if (state == RESPOND) begin
            valid[reqIdx][vicWay] <= 1'b1;
            dirty[reqIdx][vicWay] <= reqWr;
            tags[reqIdx][vicWay] <= reqTag;
            lines[reqIdx][vicWay] <= reqWr ? reqData : memData;
            plru[reqIdx] <= treeNew;
         end
      end
   end
`ifdef CACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         oHitCnt <= '0;
         oMissCnt <= '0;
      end else if (oReady) begin
         if (oHit && oHitCnt != '1) oHitCnt <= oHitCnt + 1'b1;
         if (!oHit && oMissCnt != '1) oMissCnt <= oMissCnt + 1'b1;
      end
   end
`endif
endmodule
